cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
Parametrised multi-cycle CPU control sequencer, successor to the fixed 4-state fetch/load/execute controller.
- Adds a memory fetch handshake, a latched instruction register and a multi-cycle ALU handshake.
- Adds a writeback state, a halt instruction, a run gate and a retired-instruction counter.
- Drives datapath register enables, mux selects and ALU opcode for the existing datapath (regs 1-5, muxA/muxB, mux2).

Parameters:
SEL_W, 2, width of each ALU input mux select field.
OP_W, 3, width of ALU opcode field.
CNT_W, 16, width of retired-instruction counter.
TIMEOUT, 15, max consecutive wait cycles before error (only with CTRL_TIMEOUT_EN); legal range 1..255.
Derived (localparam): CMD_W = 2*SEL_W+OP_W+1.
- cmd layout: [CMD_W-1]=halt, then sel_a, then sel_b, then opcode in LSBs.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  enable fetching of new instructions
cmd_in  in  CMD_W  instruction word from instruction memory
mem_ack  in  1  instruction memory acknowledge, cmd_in valid this cycle
alu_done  in  1  ALU result ready
mem_req  out  1  instruction fetch request
datain_reg_en  out  1  reg5 load / instruction capture strobe
aluin_reg_en  out  1  reg1/reg2 load
aluout_reg_en  out  1  reg3/reg4 load
alu_start  out  1  one-cycle ALU start pulse
mem_write  out  1  data memory write
mem_read  out  1  data memory read
selmux2  out  1  mux2 select
cpu_rdy  out  1  instruction retiring this cycle
nvalid_data  out  1  active-high "data not valid"
in_select_a  out  SEL_W  muxA select
in_select_b  out  SEL_W  muxB select
opcode  out  OP_W  ALU operation
halted  out  1  in HALT state
err  out  1  in ERROR state
instr_cnt  out  CNT_W  retired-instruction count
state_o  out  3  current state encoding

Behaviour:
- States and encodings:
  - RESET=0, FETCH=1, LOAD=2, EXEC=3, WB=4, HALT=5, ERROR=6.
  - Code 7 is unused and recovers to RESET next cycle.
- Reset values:
  - state=RESET; ir=0; instr_cnt=0; wait counter=0.
  - All outputs 0 except nvalid_data=1.
  - Reset mid-instruction aborts immediately (async); no partial writeback.
- Transitions:
  - RESET -> FETCH unconditionally.
  - FETCH: mem_req=run.
    - run&mem_ack: ir<=cmd_in, datain_reg_en=1 that cycle, go to LOAD.
    - mem_ack while run=0 is ignored.
  - LOAD (1 cycle): aluin_reg_en=1; in_select_a/in_select_b come from ir; -> EXEC.
  - EXEC: opcode=ir op field throughout. alu_start=1 only in the first EXEC cycle.
    - alu_done is sampled every EXEC cycle, including the first; done -> WB.
  - WB (1 cycle): aluout_reg_en=1, mem_read=1, selmux2=1, cpu_rdy=1, mem_write=1, nvalid_data=0.
    - opcode held. instr_cnt+1, wrapping all-ones -> 0.
    - Next state: HALT if ir halt bit=1, else FETCH.
  - HALT and ERROR are terminal: outputs idle, halted/err=1. Only rst exits.
- Moore outputs decode from state (and ir) only, except datain_reg_en, which is qualified by mem_ack in FETCH.
- Idle values in any state where an output is not listed: 0, nvalid_data=1, selects 0, opcode 0.
- Latency:
  - Minimum 4 cycles/instruction (FETCH with immediate ack, LOAD, EXEC with immediate done, WB).
  - First mem_req is 1 cycle after reset release.
- cmd_in is sampled only on the capture cycle; later changes do not affect the instruction in flight.

Optional Feature:
CTRL_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to FETCH or EXEC.
  - It increments each FETCH cycle with mem_req=1&!mem_ack, and each EXEC cycle with !alu_done.
  - When the TIMEOUT-th consecutive waiting cycle completes without ack/done -> ERROR.
  - An ack/done arriving on that same cycle wins, and normal flow continues.
  - run=0 cycles in FETCH do not count.
- Undefined: no counter; waits are unbounded; err tied 0; ERROR state unreachable.

Test Plan:
- Reset release, run=1, mem_ack=1 always, alu_done=1 always, cmd=0x4D (halt=0, sel_a=2, sel_b=1, op=5):
  - state sequence 0,1,2,3,4,1.
  - In LOAD: in_select_a=2, in_select_b=1.
  - In EXEC: opcode=5, alu_start=1.
  - cpu_rdy once per 4 cycles; instr_cnt=3 after 12 cycles of FETCH-start.
- mem_ack held low 5 cycles, then pulsed with cmd=0x4D:
  - mem_req high for 6 cycles; datain_reg_en only on the ack cycle.
  - cmd_in changed to 0x00 in LOAD: select/opcode still follow 0x4D.
- alu_done asserted 3 cycles after EXEC entry: EXEC lasts 4 cycles; alu_start high only in cycle 1; WB follows.
- cmd=0xCD (halt=1): after WB, state=5, halted=1, mem_req=0 indefinitely; rst returns to RESET with instr_cnt=0.
- CTRL_TIMEOUT_EN, TIMEOUT=15:
  - No ack: ERROR after 15 waiting cycles, err=1.
  - Repeat with ack on the 15th waiting cycle: proceeds to LOAD, err=0.
- Async rst asserted mid-EXEC: outputs return to reset values before the next clk edge. CNT_W=2: instr_cnt wraps 3 -> 0 on the 4th retire.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle CPU control sequencer: fetch handshake, instruction latch, ALU handshake,
// writeback, halt and retired-instruction count. Optional wait timeout: CTRL_TIMEOUT_EN.
module cpu_ctrl_seq #(
  parameter int SEL_W   = 2,
  parameter int OP_W    = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [2*SEL_W+OP_W:0]    cmd_in,
  input  logic                     mem_ack,
  input  logic                     alu_done,
  output logic                     mem_req,
  output logic                     datain_reg_en,
  output logic                     aluin_reg_en,
  output logic                     aluout_reg_en,
  output logic                     alu_start,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic                     selmux2,
  output logic                     cpu_rdy,
  output logic                     nvalid_data,
  output logic [SEL_W-1:0]         in_select_a,
  output logic [SEL_W-1:0]         in_select_b,
  output logic [OP_W-1:0]          opcode,
  output logic                     halted,
  output logic                     err,
  output logic [CNT_W-1:0]         instr_cnt,
  output logic [2:0]               state_o
);

  localparam int CMD_W = 2*SEL_W + OP_W + 1;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("cpu_ctrl_seq: TIMEOUT must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               timeout_hit;

`ifdef CTRL_TIMEOUT_EN
  localparam logic ERR_EN = 1'b1;
  logic [7:0] wait_q, wait_d;
  logic       waiting;

  // A wait cycle is a fetch request without ack, or an EXEC cycle without done.
  always_comb begin
    waiting     = ((state_q == S_FETCH) && run && !mem_ack) ||
                  ((state_q == S_EXEC) && !alu_done);
    timeout_hit = waiting && (wait_q == 8'(TIMEOUT - 1));
    if (((state_d == S_FETCH) && (state_q != S_FETCH)) ||
        ((state_d == S_EXEC) && (state_q != S_EXEC))) begin
      wait_d = 8'd0;
    end else if (waiting) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  localparam logic ERR_EN = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  // State, instruction register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      ir_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; ack/done in the same cycle as a timeout takes priority.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (run && mem_ack) begin
          ir_d    = cmd_in;
          state_d = S_LOAD;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LOAD: begin
        state_d = S_EXEC;
        first_d = 1'b1;
      end
      S_EXEC: begin
        if (alu_done) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WB: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ir_q[CMD_W-1] ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  // Output decode from state and ir; only the fetch strobes see live inputs.
  always_comb begin
    mem_req       = 1'b0;
    datain_reg_en = 1'b0;
    aluin_reg_en  = 1'b0;
    aluout_reg_en = 1'b0;
    alu_start     = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    selmux2       = 1'b0;
    cpu_rdy       = 1'b0;
    nvalid_data   = 1'b1;
    in_select_a   = '0;
    in_select_b   = '0;
    opcode        = '0;
    halted        = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req       = run;
        datain_reg_en = run & mem_ack;
      end
      S_LOAD: begin
        aluin_reg_en = 1'b1;
        in_select_a  = ir_q[CMD_W-2 -: SEL_W];
        in_select_b  = ir_q[OP_W +: SEL_W];
      end
      S_EXEC: begin
        opcode    = ir_q[OP_W-1:0];
        alu_start = first_q;
      end
      S_WB: begin
        opcode        = ir_q[OP_W-1:0];
        aluout_reg_en = 1'b1;
        mem_read      = 1'b1;
        mem_write     = 1'b1;
        selmux2       = 1'b1;
        cpu_rdy       = 1'b1;
        nvalid_data   = 1'b0;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: err    = ERR_EN;
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign instr_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed table, hand sequences and random stimulus against a
// behavioural model. A second instance with CNT_W=2 checks counter wrap.
module tb_cpu_ctrl_seq;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst, run, mem_ack, alu_done;
  logic [7:0] cmd_in;
  logic mem_req, datain_reg_en, aluin_reg_en, aluout_reg_en, alu_start, mem_write, mem_read;
  logic selmux2, cpu_rdy, nvalid_data, halted, err;
  logic [1:0] in_select_a, in_select_b;
  logic [2:0] opcode, state_o;
  logic [15:0] instr_cnt;
  logic d2_mem_req, d2_din, d2_aluin, d2_aluout, d2_start, d2_mw, d2_mr, d2_sel2, d2_rdy;
  logic d2_nval, d2_halted, d2_err;
  logic [1:0] d2_sa, d2_sb, d2_cnt;
  logic [2:0] d2_op, d2_state;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model of the instruction flow.
  int m_ph, m_wait, m_exc, m_cnt;
  logic [7:0] m_ir;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.SEL_W(2), .OP_W(3), .CNT_W(16), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .run(run), .cmd_in(cmd_in), .mem_ack(mem_ack), .alu_done(alu_done),
    .mem_req(mem_req), .datain_reg_en(datain_reg_en), .aluin_reg_en(aluin_reg_en),
    .aluout_reg_en(aluout_reg_en), .alu_start(alu_start), .mem_write(mem_write),
    .mem_read(mem_read), .selmux2(selmux2), .cpu_rdy(cpu_rdy), .nvalid_data(nvalid_data),
    .in_select_a(in_select_a), .in_select_b(in_select_b), .opcode(opcode), .halted(halted),
    .err(err), .instr_cnt(instr_cnt), .state_o(state_o));

  cpu_ctrl_seq #(.SEL_W(2), .OP_W(3), .CNT_W(2), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .rst(rst), .run(run), .cmd_in(cmd_in), .mem_ack(mem_ack), .alu_done(alu_done),
    .mem_req(d2_mem_req), .datain_reg_en(d2_din), .aluin_reg_en(d2_aluin),
    .aluout_reg_en(d2_aluout), .alu_start(d2_start), .mem_write(d2_mw), .mem_read(d2_mr),
    .selmux2(d2_sel2), .cpu_rdy(d2_rdy), .nvalid_data(d2_nval), .in_select_a(d2_sa),
    .in_select_b(d2_sb), .opcode(d2_op), .halted(d2_halted), .err(d2_err),
    .instr_cnt(d2_cnt), .state_o(d2_state));

  typedef struct {
    logic run, ack, done;
    logic [7:0] cmd;
    logic [2:0] st;
    logic req, din, start, rdy;
    logic [1:0] sa, sb;
    logic [2:0] op;
    logic [15:0] cnt;
  } row_t;

  function automatic logic [37:0] act_vec();
    return {state_o, mem_req, datain_reg_en, aluin_reg_en, aluout_reg_en, alu_start,
            mem_write, mem_read, selmux2, cpu_rdy, nvalid_data, in_select_a, in_select_b,
            opcode, halted, err, instr_cnt};
  endfunction

  function automatic logic [37:0] exp_vec();
    logic wb, ld, ex;
    logic [1:0] sa, sb;
    logic [2:0] op;
    wb = (m_ph == 4);
    ld = (m_ph == 2);
    ex = (m_ph == 3);
    sa = ld ? m_ir[6:5] : 2'd0;
    sb = ld ? m_ir[4:3] : 2'd0;
    op = (ex || wb) ? m_ir[2:0] : 3'd0;
    return {3'(m_ph), (m_ph == 1) & run, (m_ph == 1) & run & mem_ack, ld, wb,
            ex && (m_exc == 0), wb, wb, wb, wb, !wb, sa, sb, op,
            (m_ph == 5), (m_ph == 6), 16'(m_cnt)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_exc = 0; m_cnt = 0; m_ir = 8'h00;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_adv();
    case (m_ph)
      0: begin m_ph = 1; m_wait = 0; end
      1: begin
        if (run && mem_ack) begin
          m_ir = cmd_in; m_ph = 2;
        end else if (run) begin
          m_wait++;
`ifdef CTRL_TIMEOUT_EN
          if (m_wait == TO) m_ph = 6;
`endif
        end
      end
      2: begin m_ph = 3; m_exc = 0; m_wait = 0; end
      3: begin
        m_exc++;
        if (alu_done) m_ph = 4;
        else begin
          m_wait++;
`ifdef CTRL_TIMEOUT_EN
          if (m_wait == TO) m_ph = 6;
`endif
        end
      end
      4: begin
        m_cnt = (m_cnt + 1) % 65536;
        m_ph = m_ir[7] ? 5 : 1;
        m_wait = 0;
      end
      default: m_ph = m_ph;
    endcase
  endtask

  task automatic setin(input logic r, input logic a, input logic d, input logic [7:0] c);
    run = r; mem_ack = a; alu_done = d; cmd_in = c;
  endtask

  // One clock: model check late in the cycle, then the edge.
  task automatic cyc();
    #4;
    chk("cycle", 64'(act_vec()), 64'(exp_vec()));
    chk("cnt_w2", 64'(d2_cnt), 64'(m_cnt % 4));
    @(posedge clk);
    if (!rst) model_adv();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("reset_vec", 64'(act_vec()), 64'(exp_vec()));
    chk("reset_state", 64'(state_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  row_t tbl[10];

  initial begin
    setin(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    model_reset();
    #2;
    do_reset();

    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd5, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd5, 16'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 16'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 16'd1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd5, 16'd1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd5, 16'd1};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 8'h4D, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 16'd2};
    for (int i = 0; i < 10; i++) begin
      setin(tbl[i].run, tbl[i].ack, tbl[i].done, tbl[i].cmd);
      #3;
      chk("tbl_row", 64'({state_o, mem_req, datain_reg_en, alu_start, cpu_rdy,
                          in_select_a, in_select_b, opcode, instr_cnt}),
          64'({tbl[i].st, tbl[i].req, tbl[i].din, tbl[i].start, tbl[i].rdy,
               tbl[i].sa, tbl[i].sb, tbl[i].op, tbl[i].cnt}));
      cyc();
    end

    // Delayed fetch ack, cmd_in change after capture, delayed ALU done.
    do_reset();
    setin(1'b1, 1'b0, 1'b0, 8'h4D);
    cyc();
    for (int i = 0; i < 5; i++) begin
      setin(1'b1, 1'b0, 1'b0, 8'h4D);
      #3;
      chk("wait_req_din", 64'({mem_req, datain_reg_en}), 64'(2'b10));
      cyc();
    end
    setin(1'b1, 1'b1, 1'b0, 8'h4D);
    #3;
    chk("ack_req_din", 64'({mem_req, datain_reg_en}), 64'(2'b11));
    cyc();
    setin(1'b1, 1'b0, 1'b0, 8'h00);
    #3;
    chk("load_sel", 64'({state_o, in_select_a, in_select_b}), 64'({3'd2, 2'd2, 2'd1}));
    cyc();
    for (int i = 0; i < 4; i++) begin
      setin(1'b1, 1'b0, (i == 3), 8'h00);
      #3;
      chk("exec_cyc", 64'({state_o, alu_start, opcode}), 64'({3'd3, (i == 0), 3'd5}));
      cyc();
    end
    #3;
    chk("wb_after_exec", 64'(state_o), 64'd4);
    cyc();

    // Halt instruction, then reset clears the counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      setin(1'b1, 1'b1, 1'b1, 8'hCD);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("halt_hold", 64'({state_o, halted, mem_req}), 64'({3'd5, 1'b1, 1'b0}));
      cyc();
    end
    do_reset();
    chk("cnt_after_rst", 64'(instr_cnt), 64'd0);

    // Async reset in the middle of EXEC.
    setin(1'b1, 1'b1, 1'b0, 8'h4D);
    cyc(); cyc(); cyc();
    #2;
    chk("pre_rst_exec", 64'(state_o), 64'd3);
    do_reset();

    // Four retires wrap the 2-bit counter instance.
    setin(1'b1, 1'b1, 1'b1, 8'h4D);
    for (int i = 0; i < 17; i++) cyc();
    chk("wrap_cnt2", 64'({d2_cnt, instr_cnt}), 64'({2'd0, 16'd4}));

`ifdef CTRL_TIMEOUT_EN
    do_reset();
    setin(1'b1, 1'b0, 1'b0, 8'h4D);
    cyc();
    for (int i = 0; i < TO; i++) cyc();
    #3;
    chk("timeout_err", 64'({state_o, err}), 64'({3'd6, 1'b1}));
    cyc();
    do_reset();
    setin(1'b1, 1'b0, 1'b0, 8'h4D);
    cyc();
    for (int i = 0; i < TO - 1; i++) cyc();
    setin(1'b1, 1'b1, 1'b0, 8'h4D);
    cyc();
    #3;
    chk("ack_wins", 64'({state_o, err}), 64'({3'd2, 1'b0}));
    cyc();
`endif

    // Random stimulus against the model.
    do_reset();
    begin
      int stuck;
      stuck = 0;
      for (int i = 0; i < 3000; i++) begin
        logic [7:0] c;
        c = 8'($urandom);
        if ($urandom % 16 != 0) c[7] = 1'b0;
        setin(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0, c);
        if (m_ph == 5 || m_ph == 6) stuck++;
        if (stuck > 3 || ($urandom % 300) == 0) begin
          #($urandom_range(1, 3));
          do_reset();
          stuck = 0;
        end else begin
          cyc();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
